// File: rtl/ps2_host.sv
// PS/2 host controller: receives device frames into an RX FIFO and, when
// PS2_HOST_TX_EN is defined, sends command bytes using the inhibit/request-to-send sequence.
module ps2_host #(
  parameter int FIFO_BITS   = 4,
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rd,
  output logic       rx_err,
  output logic       rx_ovf,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  output logic       tx_err
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int WDW   = $clog2(TIMEOUT_CYC + 1);
  localparam int INW   = $clog2(INHIBIT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, RX_BITS, RX_PAR, RX_STOP, TX_INH, TX_BITS, TX_ACK, TX_WAITHI
  } state_t;

  state_t state, state_n;

  logic clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
  logic fall;
  logic [3:0] bit_cnt;
  logic [7:0] rx_sh;
  logic par_r;
  logic [WDW-1:0] wd_cnt;
  logic watched, wd_hit;
  logic rx_err_n, push_n, push_req;

  // input synchronizers; lines idle high
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1; clk_s3 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in; clk_s2 <= clk_s1; clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat_in; dat_s2 <= dat_s1;
    end
  end

  assign fall    = clk_s3 & ~clk_s2;
  assign watched = state inside {RX_BITS, RX_PAR, RX_STOP, TX_BITS, TX_ACK};
  assign wd_hit  = watched && !fall && (wd_cnt == WDW'(TIMEOUT_CYC - 1));

`ifdef PS2_HOST_TX_EN
  logic [9:0]     tx_sh;
  logic [INW-1:0] inh_cnt;
  logic           tx_err_n, tx_load, dat_out_n;
  logic           clk_out, dat_out;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    rx_err_n = 1'b0;
    push_n   = 1'b0;
`ifdef PS2_HOST_TX_EN
    tx_err_n  = 1'b0;
    tx_load   = 1'b0;
    dat_out_n = 1'b1;
`endif
    case (state)
      IDLE:    if (fall && !dat_s2) state_n = RX_BITS;
      RX_BITS: if (fall && bit_cnt == 4'd7) state_n = RX_PAR;
      RX_PAR:  if (fall) state_n = RX_STOP;
      RX_STOP: if (fall) begin
        if ((^{rx_sh, par_r}) && dat_s2) push_n = 1'b1;
        else                             rx_err_n = 1'b1;
        state_n = IDLE;
      end
`ifdef PS2_HOST_TX_EN
      TX_INH: if (inh_cnt == INW'(INHIBIT_CYC - 1)) begin
        state_n   = TX_BITS;
        dat_out_n = 1'b0;
      end
      // bit_cnt 0..9 put data, parity, stop; the fall after stop moves on
      TX_BITS: begin
        dat_out_n = dat_out;
        if (fall) begin
          if (bit_cnt == 4'd10) state_n = TX_ACK;
          else                  dat_out_n = tx_sh[0];
        end
      end
      TX_ACK: if (fall) begin
        tx_err_n = dat_s2;
        state_n  = TX_WAITHI;
      end
      TX_WAITHI: if (clk_s2 && dat_s2) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase

    if (wd_hit) begin
      state_n = IDLE;
`ifdef PS2_HOST_TX_EN
      dat_out_n = 1'b1;
      if (state inside {TX_BITS, TX_ACK}) tx_err_n = 1'b1;
      else                                rx_err_n = 1'b1;
`else
      rx_err_n = 1'b1;
`endif
    end

`ifdef PS2_HOST_TX_EN
    // a command preempts a receive in progress without reporting it
    if (tx_we && (state inside {IDLE, RX_BITS, RX_PAR, RX_STOP})) begin
      state_n  = TX_INH;
      tx_load  = 1'b1;
      rx_err_n = 1'b0;
      push_n   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      rx_sh    <= '0;
      par_r    <= 1'b0;
      wd_cnt   <= '0;
      rx_err   <= 1'b0;
      push_req <= 1'b0;
    end else begin
      if (state_n != state)
        bit_cnt <= '0;
      else if (fall && (state == RX_BITS || state == TX_BITS))
        bit_cnt <= bit_cnt + 4'd1;
      if (state == RX_BITS && fall) rx_sh <= {dat_s2, rx_sh[7:1]};
      if (state == RX_PAR && fall)  par_r <= dat_s2;
      if (!watched || fall || state_n != state) wd_cnt <= '0;
      else                                      wd_cnt <= wd_cnt + 1'b1;
      rx_err   <= rx_err_n;
      push_req <= push_n;
    end
  end

`ifdef PS2_HOST_TX_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tx_sh   <= '0;
      inh_cnt <= '0;
      tx_err  <= 1'b0;
      clk_out <= 1'b1;
      dat_out <= 1'b1;
    end else begin
      tx_err  <= tx_err_n;
      dat_out <= dat_out_n;
      clk_out <= (state != TX_INH);
      inh_cnt <= (state == TX_INH) ? inh_cnt + 1'b1 : '0;
      if (tx_load)
        tx_sh <= {1'b1, ~^tx_data, tx_data};
      else if (state == TX_BITS && fall && bit_cnt != 4'd10)
        tx_sh <= {1'b1, tx_sh[9:1]};
    end
  end

  assign ps2_clk_out = clk_out;
  assign ps2_dat_out = dat_out;
  assign tx_busy     = state inside {TX_INH, TX_BITS, TX_ACK, TX_WAITHI};
`else
  logic unused_tx;
  assign unused_tx   = ^{tx_data, tx_we};
  assign ps2_clk_out = 1'b1;
  assign ps2_dat_out = 1'b1;
  assign tx_busy     = 1'b0;
  assign tx_err      = 1'b0;
`endif

  // RX FIFO; rx_sh holds the finished byte through the push cycle
  logic [7:0]           mem [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_BITS:0]   count;
  logic                 full, pop, wr;

  assign full     = (count == (FIFO_BITS + 1)'(DEPTH));
  assign rx_valid = (count != '0);
  assign pop      = rx_rd && rx_valid;
  assign wr       = push_req && (!full || pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk_sys) begin
    if (wr) mem[wr_ptr] <= rx_sh;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rx_ovf <= 1'b0;
    end else begin
      rx_ovf <= push_req && full && !pop;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host.sv
// Directed bench for ps2_host: device-side frame driver, FIFO, errors, timeout, reset, TX.
module tb_ps2_host;
  localparam int H   = 10;
  localparam int TMO = 300;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_dev = 1'b1, dat_dev = 1'b1;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_out, ps2_dat_out;
  logic [7:0] rx_data, tx_data = 8'h00;
  logic       rx_valid, rx_rd = 1'b0, rx_err, rx_ovf;
  logic       tx_we = 1'b0, tx_busy, tx_err;

  int checks = 0, errors = 0;
  int n_rx_err = 0, n_ovf = 0, n_tx_err = 0;

  // wired-AND open-drain lines
  assign ps2_clk_in = clk_dev & ps2_clk_out;
  assign ps2_dat_in = dat_dev & ps2_dat_out;

  ps2_host #(.FIFO_BITS(4), .INHIBIT_CYC(5000), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd),
    .rx_err(rx_err), .rx_ovf(rx_ovf),
    .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy), .tx_err(tx_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (rx_err) n_rx_err++;
    if (rx_ovf) n_ovf++;
    if (tx_err) n_tx_err++;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_clk_out"}, ps2_clk_out, 1);
    chk({tag, "_dat_out"}, ps2_dat_out, 1);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_err"}, rx_err, 0);
    chk({tag, "_rx_ovf"}, rx_ovf, 0);
    chk({tag, "_tx_busy"}, tx_busy, 0);
    chk({tag, "_tx_err"}, tx_err, 0);
  endtask

  // nbits < 8 sends only start + nbits data bits; mode 1 checks push latency,
  // mode 2 pops exactly on the push edge
  task automatic frame(input logic [7:0] d, input logic par, input logic stop,
                       input int nbits, input int mode);
    logic [10:0] bits;
    int nb;
    bits = {stop, par, d, 1'b0};
    nb = (nbits < 8) ? nbits + 1 : 11;
    for (int i = 0; i < nb; i++) begin
      dat_dev = bits[i];
      tick(H);
      clk_dev = 1'b0;
      if (i == 10 && mode == 1) begin
        tick(3); chk("rx_latency_e3", rx_valid, 0);
        tick(1); chk("rx_latency_e4", rx_valid, 1);
        tick(H - 4);
      end else if (i == 10 && mode == 2) begin
        tick(3); rx_rd = 1'b1;
        tick(1); rx_rd = 1'b0;
        tick(H - 4);
      end else tick(H);
      clk_dev = 1'b1;
    end
    dat_dev = 1'b1;
    tick(H);
  endtask

  task automatic good(input logic [7:0] d);
    frame(d, ~^d, 1'b1, 8, 0);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, rx_valid, 1);
    chk({tag, "_data"}, rx_data, exp);
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
  endtask

`ifdef PS2_HOST_TX_EN
  task automatic tx_run(input logic [7:0] d, input logic ack);
    int lo, e_tx, e_rx;
    logic [9:0] exp_bits;
    e_tx = n_tx_err; e_rx = n_rx_err;
    tx_data = d; tx_we = 1'b1;
    tick(1);
    tx_we = 1'b0;
    chk("tx_busy_rise", tx_busy, 1);
    chk("tx_clk_hold", ps2_clk_out, 1);
    lo = 0;
    tick(1);
    while (ps2_clk_out == 1'b0 && lo < 6000) begin lo++; tick(1); end
    chk("tx_inhibit_len", lo, 5000);
    chk("tx_start_bit", ps2_dat_out, 0);
    exp_bits = {1'b1, ~^d, d};
    for (int k = 0; k < 10; k++) begin
      tick(H); clk_dev = 1'b0;
      tick(H); chk("tx_bit", ps2_dat_out, exp_bits[k]);
      clk_dev = 1'b1;
    end
    tick(H);
    dat_dev = ack;
    for (int j = 0; j < 2; j++) begin
      clk_dev = 1'b0; tick(H);
      clk_dev = 1'b1; tick(H);
    end
    if (ack == 1'b0) chk("tx_busy_wait_hi", tx_busy, 1);
    dat_dev = 1'b1;
    lo = 0;
    while (tx_busy && lo < 100) begin lo++; tick(1); end
    chk("tx_busy_fall", tx_busy, 0);
    chk("tx_err_count", n_tx_err - e_tx, ack ? 1 : 0);
    chk("tx_no_rx_err", n_rx_err - e_rx, 0);
    chk("tx_clk_released", ps2_clk_out, 1);
    chk("tx_dat_released", ps2_dat_out, 1);
  endtask
`endif

  initial begin
    int e0;
    tick(3);
    chk_reset("reset");
    reset_n = 1'b1;
    tick(2);

    // good byte, exact push latency, then pop
    e0 = n_rx_err;
    frame(8'h1C, 1'b0, 1'b1, 8, 1);
    chk("rx1_err", n_rx_err - e0, 0);
    pop_chk("rx1", 8'h1C);
    chk("rx1_empty", rx_valid, 0);

    // bad parity, bad stop
    e0 = n_rx_err;
    frame(8'h1C, 1'b1, 1'b1, 8, 0);
    chk("par_err", n_rx_err - e0, 1);
    chk("par_no_push", rx_valid, 0);
    e0 = n_rx_err;
    frame(8'h1C, 1'b0, 1'b0, 8, 0);
    chk("stop_err", n_rx_err - e0, 1);
    chk("stop_no_push", rx_valid, 0);

    // clock pulse with data high in idle is ignored
    e0 = n_rx_err;
    clk_dev = 1'b0; tick(H); clk_dev = 1'b1; tick(H);
    chk("idle_fall_err", n_rx_err - e0, 0);
    chk("idle_fall_valid", rx_valid, 0);

    // overflow: 17 bytes into 16 slots
    e0 = n_ovf;
    for (int i = 0; i < 17; i++) good(8'(i));
    chk("ovf_count", n_ovf - e0, 1);
    for (int i = 0; i < 16; i++) pop_chk("ovf_pop", 8'(i));
    chk("ovf_empty", rx_valid, 0);

    // full FIFO with pop on the push edge: no overflow, byte kept
    for (int i = 0; i < 16; i++) good(8'(8'h20 + i));
    e0 = n_ovf;
    frame(8'h30, ~^8'h30, 1'b1, 8, 2);
    chk("full_pushpop_ovf", n_ovf - e0, 0);
    for (int i = 1; i < 17; i++) pop_chk("full_pop", 8'(8'h20 + i));
    chk("full_empty", rx_valid, 0);

    // device stalls after 4 data bits
    e0 = n_rx_err;
    frame(8'hC3, 1'b0, 1'b1, 4, 0);
    tick(TMO - 40);
    chk("tmo_early", n_rx_err - e0, 0);
    tick(40);
    chk("tmo_err", n_rx_err - e0, 1);
    chk("tmo_no_push", rx_valid, 0);
    good(8'h5A);
    pop_chk("after_tmo", 8'h5A);

`ifdef PS2_HOST_TX_EN
    tx_run(8'hED, 1'b0);
    tx_run(8'hED, 1'b1);
    good(8'hF4);
    pop_chk("after_tx", 8'hF4);
`else
    e0 = n_tx_err;
    tx_data = 8'hED; tx_we = 1'b1;
    tick(1); tx_we = 1'b0;
    tick(5);
    chk("rxonly_busy", tx_busy, 0);
    chk("rxonly_clk", ps2_clk_out, 1);
    chk("rxonly_dat", ps2_dat_out, 1);
    chk("rxonly_tx_err", n_tx_err - e0, 0);
`endif

    // reset mid-frame with a byte queued
    good(8'h33);
    chk("pre_reset_valid", rx_valid, 1);
    frame(8'hA5, 1'b0, 1'b1, 3, 0);
    dat_dev = 1'b0; tick(H); clk_dev = 1'b0; tick(3);
    reset_n = 1'b0;
    #1;
    chk_reset("midreset");
    clk_dev = 1'b1; dat_dev = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);

`ifdef PS2_HOST_TX_EN
    tx_data = 8'hFF; tx_we = 1'b1;
    tick(1); tx_we = 1'b0;
    tick(20);
    chk("inh_clk_low", ps2_clk_out, 0);
    reset_n = 1'b0;
    #1;
    chk_reset("inhreset");
    tick(3);
    reset_n = 1'b1;
    tick(3);
`endif

    good(8'h5A);
    pop_chk("post_reset", 8'h5A);
    chk("post_reset_empty", rx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
